wb_arb: RTL and testbench
=========================

# wb_arb

Write-back port arbiter for the RV32 core. It shares the register file's single write port between the in-order pipeline write-back stage and a long-latency unit (LU, e.g. mul/div) whose results come back out of order. It buffers LU results, applies an aging rule so they cannot starve, and keeps a scoreboard of destination registers with LU results still outstanding. Sits between the `wb` stage / LU and the register file; hazard outputs feed the decode-stage stall logic.

## Interface

- XLEN, 32, data width
- DEPTH, 2, LU result buffer entries (power of two, ≥1)
- MAXWAIT, 4, cycles a buffered LU result may wait before forcing a pipeline stall (≥1)

- clk  in  1  core clock; single clock domain
- rst  in  1  synchronous, active-high reset
- pipe_wen  in  1  pipeline WB stage requests a register write
- pipe_wnum  in  5  pipeline destination register
- pipe_wdata  in  XLEN  pipeline write data
- lu_valid  in  1  LU presents a result
- lu_wnum  in  5  LU destination register
- lu_wdata  in  XLEN  LU result
- lu_ready  out  1  buffer can accept; `= (count != DEPTH)`
- issue_valid  in  1  an LU op is issued this cycle
- issue_wnum  in  5  its destination register
- rs1, rs2, rd  in  5 each  decode-stage register numbers
- rs1_busy, rs2_busy, rd_busy  out  1 each  combinational scoreboard lookup; always 0 for x0
- wb_stall  out  1  pipeline must freeze; the pipe write presented this cycle is NOT taken and must be re-presented
- reg_wen  out  1  registered register-file write enable
- reg_wnum  out  5  registered write address
- rwdata  out  XLEN  registered write data

## Operation

- Pipe write is effective when `pipe_wen && pipe_wnum != 0`; x0 writes are dropped.
- LU push on `lu_valid && lu_ready`. No bypass path: a pushed entry is not eligible to drain in its push cycle. Entries with `lu_wnum == 0` are pushed normally and drain without asserting reg_wen.
- Buffer is an in-order FIFO (head/tail pointers, count 0..DEPTH). Push and pop in the same cycle are both allowed; lu_ready depends only on current count.
- Per-cycle selection, highest priority first:
  - head valid and age == MAXWAIT: wb_stall=1; pop head; head drives write port.
  - effective pipe write: pipe drives write port.
  - head valid: pop head; head drives write port.
  - otherwise reg_wen loads 0.
- Age counter: 0 when buffer empty or on pop; else +1 per cycle head waits, saturating at MAXWAIT.
- Scoreboard (32 busy bits):
  - set on `issue_valid && issue_wnum != 0`.
  - clear on pop of an entry with the same wnum.
  - same register set and cleared in the same cycle: set wins.
  - bit 0 is hardwired to 0.
- The pipeline must not issue an LU op whose rd_busy=1; this block does not check for that.

## Timing

- Reset values: reg_wen=0, reg_wnum=0, rwdata=0, wb_stall=0, age=0, count=0, scoreboard all 0; lu_ready=1 from the first cycle after reset.
- Pipe write presented in cycle N appears on reg_wen/reg_wnum/rwdata in cycle N+1.
- LU result accepted at the edge ending cycle N: earliest drain is in cycle N+1, with the write visible in cycle N+2. Its busy bit clears at the drain edge, so the scoreboard shows 0 in cycle N+2.
- wb_stall is combinational and asserted for exactly one cycle per aged head. Age restarts at 0 for the next entry.
- Full buffer: lu_ready=0 until a pop occurs. If a pop and a push happen in the same cycle, count is unchanged.
- Reset mid-operation: buffered entries are discarded, the scoreboard is cleared, and no write follows in the next cycle.

## Test plan

- Assert rst for 2 cycles with pipe_wen=1 and lu_valid=1 -> in the cycle after release, reg_wen=0, rwdata=0, lu_ready=1, all busy outputs 0.
- Pipe write x5=0x00001234 in cycle N -> in cycle N+1, reg_wen=1, reg_wnum=5, rwdata=0x00001234.
- Issue to x7 -> rd_busy=1 for rd=7. LU returns x7=0xDEADBEEF with the pipe idle -> write appears 2 cycles after acceptance, and rd_busy=0 in the same cycle.
- DEPTH=2, MAXWAIT=4, continuous pipe writes, two LU pushes -> lu_ready=0. After the head has waited 4 cycles, wb_stall=1 for one cycle and the head is written in the next cycle. The pipe write is re-presented and written after that; lu_ready returns to 1.
- Pipe write to x0 -> reg_wen stays 0. LU result with wnum=0 is accepted, drains, produces no write, and leaves the scoreboard unchanged.
- Two buffered entries and x9 busy, then rst for 1 cycle -> no writes follow, rs1_busy=0 for rs1=9, lu_ready=1.

Source files
------------

// File: rtl/wb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_arb                                                          |
// | Brief    : Register-file write-port arbiter between the pipeline WB stage  |
// |            and an out-of-order long-latency unit, with aging + scoreboard. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wb_arb #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int MAXWAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_wen,
    input  logic [4:0]      pipe_wnum,
    input  logic [XLEN-1:0] pipe_wdata,
    input  logic            lu_valid,
    input  logic [4:0]      lu_wnum,
    input  logic [XLEN-1:0] lu_wdata,
    output logic            lu_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_wnum,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
    output logic            wb_stall,
    output logic            reg_wen,
    output logic [4:0]      reg_wnum,
    output logic [XLEN-1:0] rwdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(MAXWAIT + 1);

    localparam logic [CW-1:0] c_full     = CW'(DEPTH);
    localparam logic [AW-1:0] c_maxwait  = AW'(MAXWAIT);
    localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);

    logic [4:0]      r_mem_wnum  [DEPTH];
    logic [XLEN-1:0] r_mem_wdata [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_age;
    logic [31:0]     r_busy;
    logic            r_wen;
    logic [4:0]      r_wnum;
    logic [XLEN-1:0] r_wdata;

    logic            w_head_valid;
    logic [4:0]      w_head_wnum;
    logic [XLEN-1:0] w_head_wdata;
    logic            w_aged;
    logic            w_pipe_eff;
    logic            w_push;
    logic            w_pop;
    logic            w_sel_wen;
    logic [4:0]      w_sel_wnum;
    logic [XLEN-1:0] w_sel_wdata;
    logic [31:0]     w_busy_nxt;

    assign w_head_valid = (r_count != '0);
    assign w_head_wnum  = r_mem_wnum[r_head];
    assign w_head_wdata = r_mem_wdata[r_head];
    assign w_aged       = w_head_valid && (r_age == c_maxwait);
    assign w_pipe_eff   = pipe_wen && (pipe_wnum != 5'd0);
    assign lu_ready     = (r_count != c_full);
    assign w_push       = lu_valid && lu_ready;
    // An aged head steals the port from the pipeline; otherwise it only fills idle slots.
    assign w_pop        = w_head_valid && (w_aged || !w_pipe_eff);

    assign wb_stall = w_aged;
    assign rs1_busy = r_busy[rs1];
    assign rs2_busy = r_busy[rs2];
    assign rd_busy  = r_busy[rd];
    assign reg_wen  = r_wen;
    assign reg_wnum = r_wnum;
    assign rwdata   = r_wdata;

    always_comb begin
        w_sel_wen   = 1'b0;
        w_sel_wnum  = r_wnum;
        w_sel_wdata = r_wdata;
        if (w_pop) begin
            w_sel_wen   = (w_head_wnum != 5'd0);
            w_sel_wnum  = w_head_wnum;
            w_sel_wdata = w_head_wdata;
        end else if (w_pipe_eff) begin
            w_sel_wen   = 1'b1;
            w_sel_wnum  = pipe_wnum;
            w_sel_wdata = pipe_wdata;
        end
    end

    // Set after clear so a same-cycle reissue of a draining register stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop && (w_head_wnum != 5'd0)) begin
            w_busy_nxt[w_head_wnum] = 1'b0;
        end
        if (issue_valid && (issue_wnum != 5'd0)) begin
            w_busy_nxt[issue_wnum] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_wnum[r_tail]  <= lu_wnum;
            r_mem_wdata[r_tail] <= lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= (r_tail == c_last_ptr) ? '0 : r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= (r_head == c_last_ptr) ? '0 : r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_pop || !w_head_valid) begin
            r_age <= '0;
        end else if (r_age != c_maxwait) begin
            r_age <= r_age + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_wen   <= 1'b0;
            r_wnum  <= '0;
            r_wdata <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_wen   <= w_sel_wen;
            r_wnum  <= w_sel_wnum;
            r_wdata <= w_sel_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wb_arb                                                       |
// | Brief    : Randomized scoreboard bench for wb_arb against a queue model.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_wb_arb;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 2;
    localparam int MAXWAIT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pipe_wen = 1'b0;
    logic [4:0]      pipe_wnum = '0;
    logic [XLEN-1:0] pipe_wdata = '0;
    logic            lu_valid = 1'b0;
    logic [4:0]      lu_wnum = '0;
    logic [XLEN-1:0] lu_wdata = '0;
    logic            issue_valid = 1'b0;
    logic [4:0]      issue_wnum = '0;
    logic [4:0]      rs1 = '0;
    logic [4:0]      rs2 = '0;
    logic [4:0]      rd = '0;
    logic            lu_ready;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rd_busy;
    logic            wb_stall;
    logic            reg_wen;
    logic [4:0]      reg_wnum;
    logic [XLEN-1:0] rwdata;

    wb_arb #(.XLEN(XLEN), .DEPTH(DEPTH), .MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_wen(pipe_wen), .pipe_wnum(pipe_wnum), .pipe_wdata(pipe_wdata),
        .lu_valid(lu_valid), .lu_wnum(lu_wnum), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
        .issue_valid(issue_valid), .issue_wnum(issue_wnum),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
        .wb_stall(wb_stall), .reg_wen(reg_wen), .reg_wnum(reg_wnum), .rwdata(rwdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [4:0] wnum; logic [31:0] wdata; } wr_t;
    typedef struct { logic [4:0] wnum; logic [31:0] wdata; int pc; } lu_t;

    wr_t expq[$];
    lu_t mq[$];
    bit  mbusy[32];
    int  last_pop = -1;
    bit  m_stall = 1'b0;
    int  total = 0;
    int  bad = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: registered write port against the queue of expected writes.
    initial begin
        forever begin
            wr_t e;
            @(negedge clk);
            if (reg_wen === 1'b1) begin
                if (expq.size() == 0 || expq[0].cyc != cyc) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got x%0d=%h at cycle %0d, required no write",
                             reg_wnum, rwdata, cyc);
                end else begin
                    e = expq.pop_front();
                    chk("reg_wnum", 32'(reg_wnum), 32'(e.wnum));
                    chk("rwdata", rwdata, e.wdata);
                end
            end else if (expq.size() != 0 && expq[0].cyc == cyc) begin
                e = expq.pop_front();
                total++;
                bad++;
                $display("FAIL missing_write: got reg_wen=%b at cycle %0d, required x%0d=%h",
                         reg_wen, cyc, e.wnum, e.wdata);
            end
        end
    end

    // Drive one cycle, check combinational outputs, advance the model.
    task automatic step(input bit r, input bit pw, input logic [4:0] pn, input logic [31:0] pd,
                        input bit lv, input logic [4:0] ln, input logic [31:0] ld,
                        input bit iv, input logic [4:0] iw,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        bit  pipe_eff, aged, ready, pop;
        int  waited, start;
        lu_t h;
        @(negedge clk);
        rst = r; pipe_wen = pw; pipe_wnum = pn; pipe_wdata = pd;
        lu_valid = lv; lu_wnum = ln; lu_wdata = ld;
        issue_valid = iv; issue_wnum = iw; rs1 = a; rs2 = b; rd = d;
        #1;
        m_stall = 1'b0;
        if (!r) begin
            pipe_eff = pw && (pn != 5'd0);
            ready    = (mq.size() < DEPTH);
            aged     = 1'b0;
            if (mq.size() > 0) begin
                h      = mq[0];
                start  = ((h.pc > last_pop) ? h.pc : last_pop) + 1;
                waited = cyc - start;
                aged   = (waited >= MAXWAIT);
            end
            m_stall = aged;
            chk("wb_stall", 32'(wb_stall), 32'(aged));
            chk("lu_ready", 32'(lu_ready), 32'(ready));
            chk("rs1_busy", 32'(rs1_busy), 32'(mbusy[a]));
            chk("rs2_busy", 32'(rs2_busy), 32'(mbusy[b]));
            chk("rd_busy", 32'(rd_busy), 32'(mbusy[d]));
            pop = (mq.size() > 0) && (aged || !pipe_eff);
            if (pop) begin
                void'(mq.pop_front());
                last_pop = cyc;
                if (h.wnum != 5'd0) begin
                    expq.push_back('{cyc + 1, h.wnum, h.wdata});
                    mbusy[h.wnum] = 1'b0;
                end
            end else if (pipe_eff) begin
                expq.push_back('{cyc + 1, pn, pd});
            end
            if (lv && ready) mq.push_back('{ln, ld, cyc});
            if (iv && iw != 5'd0) mbusy[iw] = 1'b1;
        end else begin
            mq.delete();
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            last_pop = -1;
        end
    endtask

    task automatic idle(input int n, input logic [4:0] a);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, a, a, a);
    endtask

    initial begin
        logic [31:0] pdat;
        // Reset with live requests on both sources.
        step(1, 1, 5'd3, 32'hFFFF_FFFF, 1, 5'd4, 32'h5555_5555, 0, 0, 0, 0, 0);
        step(1, 1, 5'd3, 32'hFFFF_FFFF, 1, 5'd4, 32'h5555_5555, 0, 0, 0, 0, 0);
        idle(1, 5'd3);
        chk("rst_reg_wen", 32'(reg_wen), 32'd0);
        chk("rst_rwdata", rwdata, 32'd0);

        step(0, 1, 5'd5, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 5'd5);

        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 5'd7);
        idle(2, 5'd7);
        step(0, 0, 0, 0, 1, 5'd7, 32'hDEAD_BEEF, 0, 0, 5'd7, 5'd7, 5'd7);
        idle(3, 5'd7);

        // Aging under continuous pipe writes; a stalled pipe write is re-presented.
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd11, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 0, 0);
        pdat = 32'h0000_0100;
        for (int i = 0; i < 14; i++) begin
            step(0, 1, 5'd10, pdat, (i < 2), 5'(11 + i), 32'h0000_00A0 + 32'(i),
                 0, 0, 5'd11, 5'd12, 5'd10);
            if (!m_stall) pdat = pdat + 32'd1;
        end
        idle(2, 5'd12);

        step(0, 1, 5'd0, 32'h0BAD_0BAD, 1, 5'd0, 32'hCAFE_0000, 0, 0, 0, 0, 0);
        idle(3, 5'd0);

        // Buffered entries discarded by a mid-operation reset.
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 0, 0);
        step(0, 1, 5'd2, 32'h2222_2222, 1, 5'd9, 32'h9999_9999, 0, 0, 5'd9, 0, 0);
        step(0, 1, 5'd2, 32'h2222_2223, 1, 5'd4, 32'h4444_4444, 0, 0, 5'd9, 0, 0);
        step(1, 1, 5'd2, 32'h2222_2224, 0, 0, 0, 0, 0, 5'd9, 0, 0);
        idle(4, 5'd9);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
                 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(12, 5'd0);
        @(negedge clk);
        @(negedge clk);
        chk("drain_pending", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
